rr_mux: RTL
===========

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 The block SHALL have parameter N, default 4: channel count; legal range 2..16; N need not be a power of two.
REQ-003 The block SHALL have localparam SEL_W = $clog2(N): channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, N*WIDTH bits: channel i at [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, N bits: per-channel valid.
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel ready.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = round-robin (MODE_RR), 1 = fixed select (MODE_FIXED).
REQ-010 The block SHALL have port sel, input, SEL_W bits: channel index used in fixed mode.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds a beat.
REQ-013 The block SHALL have port out_ch, output, SEL_W bits: source channel of the held beat.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.

Function
REQ-015 The block SHALL compute load = !out_valid || out_ready, meaning the output register may take a new beat this cycle.
REQ-016 In fixed mode, the block SHALL grant sel only when sel < N and in_valid[sel] = 1; otherwise there SHALL be no grant.
REQ-017 In round-robin mode, the block SHALL grant the first index i with in_valid[i] = 1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-018 The block SHALL drive in_ready[i] = load && grant && grant_idx == i: at most one bit high, and combinational in the current cycle.
REQ-019 A transfer SHALL occur when in_valid[i] && in_ready[i]; on the next edge out_data = channel i data, out_ch = i, out_valid = 1 (latency 1 cycle).
REQ-020 When load = 1 and there is no grant, out_valid SHALL be 0 after the edge; out_data and out_ch SHALL keep their values.
REQ-021 While out_valid && !out_ready, out_data, out_ch and out_valid SHALL hold and in_ready SHALL be all-zero.
REQ-022 Throughput SHALL be one beat per cycle while out_ready is held at 1, including same-cycle drain and refill.
REQ-023 On a round-robin transfer, ptr SHALL become (grant_idx+1) mod N, so N-1 wraps to 0.
REQ-024 Fixed-mode transfers SHALL leave ptr unchanged.
REQ-025 mode and sel SHALL be sampled combinationally every cycle; a change during a stall SHALL take effect at the next load.
REQ-026 A valid input not granted SHALL see in_ready = 0 and may hold; the block SHALL never drop or duplicate a beat.
REQ-027 With all channels valid in round-robin mode, each channel SHALL be granted once per N consecutive transfers (no starvation).

Reset
REQ-028 While rst_n = 0, the block SHALL immediately force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0 and in_ready = 0.
REQ-029 Reset asserted mid-stall SHALL discard the held beat; after release the first round-robin grant SHALL start at channel 0.
REQ-030 Reset deassertion SHALL be synchronised by the integrator; the block assumes a clean release edge.

Structure
REQ-031 Mode encodings MODE_RR = 1'b0 and MODE_FIXED = 1'b1 SHALL live in shared header mux_defs.vh, included by this block and its bench.
REQ-032 A combinational sub-module rr_arbiter (inputs req[N], ptr; outputs grant, grant_idx) SHALL implement the rotating priority scan.
REQ-033 rr_mux SHALL contain the fixed-mode path, the output register, ptr, and the handshake logic.

Verification (N=4, WIDTH=32)
REQ-034 Reset: rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=4'b0000.
REQ-035 Fixed: mode=1, sel=0, ch0=0x0F0F0F0F, ch1=0xF0F0F0F0, both valid, out_ready=1 -> next cycle out_data=0x0F0F0F0F, out_ch=0; ptr stays 0.
REQ-036 Round-robin: mode=0, all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data stable and in_ready=4'b0000; release -> next beat from ch(out_ch+1).
REQ-038 Skip/wrap: ptr=3, only in_valid[1]=1 -> grant 1, ptr becomes 2; with N=3, mode=1, sel=3 -> no grant and out_valid=0.
REQ-039 Async reset mid-stall: rst_n to 0 between edges with out_valid=1 -> out_valid=0 without a clock edge.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Package for rr_mux: mode encodings taken from the shared header.
package rr_mux_pkg;

`include "mux_defs.vh"

    localparam logic MODE_RR    = `MUX_MODE_RR;
    localparam logic MODE_FIXED = `MUX_MODE_FIXED;

endpackage

// File: rtl/mux_defs.vh
// Shared mode encodings for the round-robin / fixed-select channel mux.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH

`define MUX_MODE_RR    1'b0
`define MUX_MODE_FIXED 1'b1

`endif

// File: rtl/rr_arbiter.sv
// Rotating-priority request scanner.
// The scan starts at ptr and wraps through N-1 back to 0.
// The result is purely combinational.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant,
    output logic [SEL_W-1:0] grant_idx
);

    int w_idx;

    // Walk the scan order backwards so the earliest hit in rotation order wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                grant     = 1'b1;
                grant_idx = SEL_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel to one registered mux.
// In round-robin mode, channels are arbitrated by a rotating pointer.
// In fixed mode, the channel given by sel is forwarded.
// The output register is a single-entry stage; it refills in the same cycle it drains.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    // Valid/ready: a beat moves on a channel in any cycle where in_valid[i] and
    // in_ready[i] are both high at the rising edge. It moves on the output in any
    // cycle where out_valid and out_ready are both high. Valid never waits on ready.

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;

    logic             w_load;
    logic             w_rr_grant;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_fixed_grant;
    logic             w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid || out_ready;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    // Fixed-mode grant. An out-of-range sel simply matches no channel.
    always_comb begin
        w_fixed_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((sel == SEL_W'(i)) && in_valid[i]) begin
                w_fixed_grant = 1'b1;
            end
        end
    end

    assign w_grant     = (mode == MODE_FIXED) ? w_fixed_grant : w_rr_grant;
    assign w_grant_idx = (mode == MODE_FIXED) ? sel : w_rr_idx;

    // Pick the granted channel's data and drive the one-hot ready.
    // Ready is held low while in reset.
    always_comb begin
        w_sel_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && w_load && w_grant;
            end
        end
    end

    // Output register and rotation pointer.
    // Only round-robin transfers advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_grant) begin
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr <= (w_grant_idx == SEL_W'(N - 1)) ? '0 : w_grant_idx + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
